// File: rtl/pipe_stage1_if.sv
// Byte-stream and issue bundle between fetch, stage 1 and stage 2.
// The slave side is the decode stage; the master side drives fetch and control.
interface pipe_stage1_if;
    logic [7:0] FetchData;
    logic       FetchValid;
    logic       FetchReady;
    logic       Stall;
    logic       Flush;
    logic [7:0] Pipe1Out;
    logic       Pipe1Valid;
    logic [7:0] OperandLo;
    logic [7:0] OperandHi;
    logic       Busy;

    modport master (
        output FetchData, FetchValid, Stall, Flush,
        input  FetchReady, Pipe1Out, Pipe1Valid,
        input  OperandLo, OperandHi, Busy
    );

    modport slave (
        input  FetchData, FetchValid, Stall, Flush,
        output FetchReady, Pipe1Out, Pipe1Valid,
        output OperandLo, OperandHi, Busy
    );
endinterface

// File: rtl/pipe_stage1.sv
// JAM-1 stage 1: assembles opcode plus 0-2 operand bytes and issues to stage 2.
// Optional PIPE1_PERF_COUNT_EN adds IssueCount/BubbleCount performance counters.
module pipe_stage1 #(
    parameter logic [7:0] NOP_OPCODE  = 8'h00,
    parameter logic [1:0] LEN2_PREFIX = 2'b11,
    parameter logic [1:0] LEN1_PREFIX = 2'b10
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef PIPE1_PERF_COUNT_EN
    output logic [15:0]       IssueCount,
    output logic [15:0]       BubbleCount,
`endif
    pipe_stage1_if.slave      bus
);

    typedef enum logic [1:0] {
        S_OP = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [7:0] op_q, op_n;
    logic [7:0] lo_q, lo_n;
    logic       len2_q, len2_n;
    logic [7:0] out_q, out_n;
    logic       valid_q, valid_n;
    logic [7:0] olo_q, olo_n;
    logic [7:0] ohi_q, ohi_n;
    logic       issue;
    logic       accept;

    assign accept         = bus.FetchValid & ~bus.Stall & ~bus.Flush;
    assign bus.FetchReady = ~bus.Stall;
    assign bus.Pipe1Out   = out_q;
    assign bus.Pipe1Valid = valid_q;
    assign bus.OperandLo  = olo_q;
    assign bus.OperandHi  = ohi_q;
    assign bus.Busy       = (state != S_OP);

    // Next-state, byte latching and issue decode; flush beats stall beats fetch.
    always_comb begin
        state_n = state;
        op_n    = op_q;
        lo_n    = lo_q;
        len2_n  = len2_q;
        out_n   = out_q;
        valid_n = valid_q;
        olo_n   = olo_q;
        ohi_n   = ohi_q;
        issue   = 1'b0;
        if (bus.Flush) begin
            state_n = S_OP;
            out_n   = NOP_OPCODE;
            valid_n = 1'b0;
            olo_n   = 8'h00;
            ohi_n   = 8'h00;
        end else if (!bus.Stall) begin
            out_n   = NOP_OPCODE;
            valid_n = 1'b0;
            if (accept) begin
                unique case (state)
                    S_OP: begin
                        if (bus.FetchData[7:6] == LEN2_PREFIX ||
                            bus.FetchData[7:6] == LEN1_PREFIX) begin
                            op_n    = bus.FetchData;
                            len2_n  = (bus.FetchData[7:6] == LEN2_PREFIX);
                            state_n = S_B1;
                        end else begin
                            issue = 1'b1;
                            out_n = bus.FetchData;
                            olo_n = 8'h00;
                            ohi_n = 8'h00;
                        end
                    end
                    S_B1: begin
                        lo_n = bus.FetchData;
                        if (len2_q) begin
                            state_n = S_B2;
                        end else begin
                            issue   = 1'b1;
                            out_n   = op_q;
                            olo_n   = bus.FetchData;
                            ohi_n   = 8'h00;
                            state_n = S_OP;
                        end
                    end
                    S_B2: begin
                        issue   = 1'b1;
                        out_n   = op_q;
                        olo_n   = lo_q;
                        ohi_n   = bus.FetchData;
                        state_n = S_OP;
                    end
                    default: state_n = S_OP;
                endcase
                valid_n = issue;
            end
        end
    end

    // State, latches and issue registers; everything holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_OP;
            op_q    <= 8'h00;
            lo_q    <= 8'h00;
            len2_q  <= 1'b0;
            out_q   <= NOP_OPCODE;
            valid_q <= 1'b0;
            olo_q   <= 8'h00;
            ohi_q   <= 8'h00;
        end else begin
            state   <= state_n;
            op_q    <= op_n;
            lo_q    <= lo_n;
            len2_q  <= len2_n;
            out_q   <= out_n;
            valid_q <= valid_n;
            olo_q   <= olo_n;
            ohi_q   <= ohi_n;
        end
    end

`ifdef PIPE1_PERF_COUNT_EN
    logic bubble;
    assign bubble = bus.Flush | (~bus.Stall & ~issue);

    // Wrapping issue/bubble counters; a flush edge counts as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IssueCount  <= 16'h0000;
            BubbleCount <= 16'h0000;
        end else begin
            if (issue)  IssueCount  <= IssueCount + 16'h0001;
            if (bubble) BubbleCount <= BubbleCount + 16'h0001;
        end
    end
`endif

endmodule
